// File: rtl/big_mux_pkg.sv
// Shared lane geometry and types for the 256-lane write demux and its clear sequencer.
package big_mux_pkg;
    localparam int LANES = 256;
    localparam int WIDTH = 4;
    localparam int SEL_W = $clog2(LANES);

    typedef enum logic {IDLE, CLEAR} demux_state_t;
    typedef logic [WIDTH-1:0] lane_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/big_demux_clr_ctr.sv
// Clear sequencer: walks one lane index per cycle while CLEAR, pulses clr_done on exit.
// busy is high for exactly LANES cycles; clr_start is ignored while already clearing.
module big_demux_clr_ctr
    import big_mux_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr_start,
    output logic busy,
    output logic clr_done,
    output logic clr_en,
    output sel_t clr_idx
);

    demux_state_t state, state_nxt;
    sel_t         cnt, cnt_nxt;
    logic         clr_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_done <= clr_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // The edge that zeroes the last lane is also the exit edge.
                if (cnt == sel_t'(LANES - 1)) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    clr_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state == CLEAR);
        clr_en  = (state == CLEAR);
        clr_idx = cnt;
    end

endmodule

// File: rtl/big_1_demux_4bit_reg.sv
// Scatters a 4-bit write into one lane of a 1024-bit registered bank; 1-cycle write latency, sequenced clear.
// Writes are refused (in_ready=0) during reset and clear. LANE_MASK_EN adds the lane_written tracking port.
module big_1_demux_4bit_reg
    import big_mux_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic [WIDTH-1:0]       in,
    input  logic                   clr_start,
    output logic                   busy,
    output logic                   clr_done,
    output logic [LANES*WIDTH-1:0] out
`ifdef LANE_MASK_EN
    ,
    output logic [LANES-1:0]       lane_written
`endif
);

    lane_t [LANES-1:0] bank;
    logic              wr_en;
    logic              clr_en;
    sel_t              clr_idx;

    big_demux_clr_ctr u_clr_ctr (
        .clk       (clk),
        .reset     (reset),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx)
    );

    assign in_ready = !reset && !busy;
    assign wr_en    = in_valid && in_ready;
    assign out      = bank;

    // A write and a clear step never share an edge: in_ready is low throughout CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank <= '0;
        end else begin
            if (wr_en)
                bank[sel] <= in;
            if (clr_en)
                bank[clr_idx] <= '0;
        end
    end

`ifdef LANE_MASK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_written <= '0;
        end else begin
            if (wr_en)
                lane_written[sel] <= 1'b1;
            if (clr_en)
                lane_written[clr_idx] <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_big_1_demux_4bit_reg.sv
// Randomized bench for big_1_demux_4bit_reg against an array-level model of the lane bank and clear walk.
module tb_big_1_demux_4bit_reg;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    sel = '0;
    logic [3:0]    din = '0;
    logic          clr_start = 1'b0;
    logic          busy;
    logic          clr_done;
    logic [1023:0] out;
`ifdef LANE_MASK_EN
    logic [255:0]  lane_written;
`endif

    big_1_demux_4bit_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in        (din),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .out       (out)
`ifdef LANE_MASK_EN
        ,
        .lane_written (lane_written)
`endif
    );

    always #5 clk = ~clk;

    // Reference: lane contents, which lanes were written, and where the clear walk stands.
    logic [3:0] m_lane [256];
    bit         m_mask [256];
    bit         m_clearing;
    int         m_pos;
    bit         m_done;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int bank_diff();
        int d = 0;
        for (int k = 0; k < 256; k++)
            if (out[k*4 +: 4] !== m_lane[k]) d++;
        return d;
    endfunction

`ifdef LANE_MASK_EN
    function automatic int mask_diff();
        int d = 0;
        for (int k = 0; k < 256; k++)
            if (lane_written[k] !== m_mask[k]) d++;
        return d;
    endfunction
`endif

    // Apply the current inputs to the model as the next rising edge will.
    task automatic model_edge();
        if (reset) begin
            foreach (m_lane[k]) begin m_lane[k] = '0; m_mask[k] = 1'b0; end
            m_clearing = 1'b0; m_pos = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (in_valid && !m_clearing) begin
                m_lane[sel] = din;
                m_mask[sel] = 1'b1;
            end
            if (m_clearing) begin
                m_lane[m_pos] = '0;
                m_mask[m_pos] = 1'b0;
                m_pos++;
                if (m_pos == 256) begin
                    m_clearing = 1'b0; m_pos = 0; m_done = 1'b1;
                end
            end else if (clr_start) begin
                m_clearing = 1'b1; m_pos = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", {31'd0, in_ready}, {31'd0, !reset && !m_clearing});
        chk("busy", {31'd0, busy}, {31'd0, m_clearing});
        chk("clr_done", {31'd0, clr_done}, {31'd0, m_done});
        chk("bank_lanes_diff", bank_diff(), 0);
`ifdef LANE_MASK_EN
        chk("mask_lanes_diff", mask_diff(), 0);
`endif
        if (busy === 1'b1) busy_cnt++;
        if (clr_done === 1'b1) done_cnt++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        foreach (m_lane[k]) begin m_lane[k] = '0; m_mask[k] = 1'b0; end
        m_clearing = 1'b0; m_pos = 0; m_done = 1'b0;

        // Reset held two cycles
        reset = 1'b1;
        #1;
        chk("ready_in_reset", {31'd0, in_ready}, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, in_ready}, 1);

        // Single write lane 5
        in_valid = 1'b1; sel = 8'h05; din = 4'hA;
        tick();
        in_valid = 1'b0;
        chk("lane5", {28'd0, out[23:20]}, 32'hA);
        tick();

        // Back-to-back writes, last write to lane 0 wins
        in_valid = 1'b1; sel = 8'd0;   din = 4'h3; tick();
        sel = 8'd255; din = 4'hF; tick();
        sel = 8'd0;   din = 4'h6; tick();
        in_valid = 1'b0;
        chk("b2b_lane0", {28'd0, out[3:0]}, 32'h6);
        chk("b2b_lane255", {28'd0, out[1023:1020]}, 32'hF);

        // Fill with 9, then full clear while a write is held pending
        in_valid = 1'b1; din = 4'h9;
        for (int i = 0; i < 256; i++) begin
            sel = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("filled_lane128", {28'd0, out[515:512]}, 32'h9);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        in_valid = 1'b1; din = 4'hF; sel = 8'd77;
        for (int i = 0; i < 258; i++) begin
            if (i == 200) in_valid = 1'b0;
            tick();
        end
        chk("clear_busy_cycles", busy_cnt, 256);
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_out_zero", {31'd0, |out}, 0);

        // Write plus clr_start on one edge; clr_start again mid-clear
        busy_cnt = 0; done_cnt = 0;
        in_valid = 1'b1; sel = 8'd3; din = 4'h7; clr_start = 1'b1;
        tick();
        in_valid = 1'b0; clr_start = 1'b0;
        chk("sim_lane3_after_start", {28'd0, out[15:12]}, 32'h7);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sim_lane3_walk", {28'd0, out[15:12]}, (i >= 4) ? 32'h0 : 32'h7);
        end
        for (int i = 6; i < 262; i++) begin
            clr_start = (i == 50);
            tick();
        end
        clr_start = 1'b0;
        chk("restart_busy_cycles", busy_cnt, 256);
        chk("restart_done_pulses", done_cnt, 1);

        // Reset 100 cycles into a clear
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sel = 8'($urandom_range(255)); din = 4'($urandom_range(1, 15));
            tick();
        end
        in_valid = 1'b0;
        done_cnt = 0;
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_out_zero", {31'd0, |out}, 0);
        chk("abort_no_done", done_cnt, 0);

`ifdef LANE_MASK_EN
        in_valid = 1'b1; sel = 8'd1; din = 4'h2; tick();
        sel = 8'd200; din = 4'h0; tick();
        in_valid = 1'b0;
        chk("mask_bit1", {31'd0, lane_written[1]}, 1);
        chk("mask_bit200", {31'd0, lane_written[200]}, 1);
        chk("mask_popcount", $countones(lane_written), 2);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        for (int i = 0; i < 257; i++) tick();
        chk("mask_after_clear", {31'd0, |lane_written}, 0);
`endif

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            sel       = 8'($urandom_range(255));
            din       = 4'($urandom);
            clr_start = ($urandom_range(299) == 0);
            reset     = ($urandom_range(999) == 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; clr_start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
